// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - EX-stage operand forwarding and load-use stall control
// Optional FWD_HAZARD_STATS_EN adds saturating stall and forward activity counters.
module fwd_hazard_ctrl #(
    parameter int LOAD_LAT = 1,
    parameter int REG_AW   = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    output logic [1:0]        forward_a_o,
    output logic [1:0]        forward_b_o,
    output logic              stall_o,
    output logic              pc_write_o,
    output logic              ifid_write_o
`ifdef FWD_HAZARD_STATS_EN
    ,
    output logic [15:0]       stall_cnt_o,
    output logic [15:0]       fwd_cnt_o
`endif
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [1:0] CNT_INIT = 2'(LOAD_LAT - 1);

    state_t            state, state_nxt;
    logic [1:0]        cnt, cnt_nxt;

    logic [REG_AW-1:0] idex_rs1, idex_rs2, idex_rd;
    logic              idex_regwrite, idex_memread;
    logic [REG_AW-1:0] exmem_rd, memwb_rd;
    logic              exmem_regwrite, memwb_regwrite;

    logic              hz;
    logic              bubble;

    assign hz = idex_memread && (idex_rd != '0) &&
                ((idex_rd == id_rs1_i) || (idex_rd == id_rs2_i));

    assign bubble       = stall_o || flush_i;
    assign pc_write_o   = ~stall_o;
    assign ifid_write_o = ~stall_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idex_rs1       <= '0;
            idex_rs2       <= '0;
            idex_rd        <= '0;
            idex_regwrite  <= 1'b0;
            idex_memread   <= 1'b0;
            exmem_rd       <= '0;
            exmem_regwrite <= 1'b0;
            memwb_rd       <= '0;
            memwb_regwrite <= 1'b0;
        end else begin
            memwb_rd       <= exmem_rd;
            memwb_regwrite <= exmem_regwrite;
            exmem_rd       <= idex_rd;
            exmem_regwrite <= idex_regwrite;
            if (bubble) begin
                idex_rs1      <= '0;
                idex_rs2      <= '0;
                idex_rd       <= '0;
                idex_regwrite <= 1'b0;
                idex_memread  <= 1'b0;
            end else begin
                idex_rs1      <= id_rs1_i;
                idex_rs2      <= id_rs2_i;
                idex_rd       <= id_rd_i;
                idex_regwrite <= id_regwrite_i;
                idex_memread  <= id_memread_i;
            end
        end
    end

    // Forward selects look only at shadow state so EX sees them with no input path.
    always_comb begin
        forward_a_o = 2'b00;
        forward_b_o = 2'b00;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == idex_rs1))
            forward_a_o = 2'b10;
        else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == idex_rs1))
            forward_a_o = 2'b01;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == idex_rs2))
            forward_b_o = 2'b10;
        else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == idex_rs2))
            forward_b_o = 2'b01;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= RUN;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The first stall cycle is spent in RUN; STALL covers the remaining LOAD_LAT-1.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_o   = 1'b0;
        if (flush_i) begin
            state_nxt = RUN;
            cnt_nxt   = 2'd0;
        end else begin
            case (state)
                RUN: begin
                    if (hz) begin
                        stall_o = 1'b1;
                        cnt_nxt = CNT_INIT;
                        if (LOAD_LAT > 1)
                            state_nxt = STALL;
                    end
                end
                STALL: begin
                    stall_o = 1'b1;
                    if (cnt <= 2'd1) begin
                        cnt_nxt   = 2'd0;
                        state_nxt = RUN;
                    end else begin
                        cnt_nxt = cnt - 2'd1;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = 2'd0;
                end
            endcase
        end
    end

`ifdef FWD_HAZARD_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= 16'd0;
            fwd_cnt_o   <= 16'd0;
        end else begin
            if (stall_o && (stall_cnt_o != 16'hFFFF))
                stall_cnt_o <= stall_cnt_o + 16'd1;
            if (((forward_a_o != 2'b00) || (forward_b_o != 2'b00)) && (fwd_cnt_o != 16'hFFFF))
                fwd_cnt_o <= fwd_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Forwarding and load-use hazard controller for the 5-stage pipeline.
- Keeps shadow copies of the destination-register fields of the ID/EX, EX/MEM and MEM/WB stages.
- Drives the 2-bit select of both EX-stage 3:1 operand muxes (A and B), and stalls PC and IF/ID on load-use hazards.
- Sits beside the hazard logic in the top-level CPU.

Parameters:
- LOAD_LAT, 1, number of stall cycles inserted per load-use hazard (legal range 1-3).
- REG_AW, 5, register-index width.

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, asynchronous, active-high
- id_rs1_i  input  REG_AW  rs1 of the instruction in ID
- id_rs2_i  input  REG_AW  rs2 of the instruction in ID
- id_rd_i  input  REG_AW  rd of the instruction in ID
- id_regwrite_i  input  1  ID instruction writes rd
- id_memread_i  input  1  ID instruction is a load
- flush_i  input  1  taken branch/jump; kill the ID instruction
- forward_a_o  output  2  operand-A mux select: 00 regfile, 01 MEM/WB, 10 EX/MEM
- forward_b_o  output  2  operand-B mux select, same encoding
- stall_o  output  1  load-use stall active
- pc_write_o  output  1  PC write enable (= ~stall_o)
- ifid_write_o  output  1  IF/ID write enable (= ~stall_o)

Behaviour:
- Shadow registers:
  - IDEX holds rs1, rs2, rd, regwrite, memread.
  - EXMEM holds rd, regwrite.
  - MEMWB holds rd, regwrite.
- Reset: all shadow fields 0, state RUN, counter 0. Outputs: forward_a_o=00, forward_b_o=00, stall_o=0, pc_write_o=1, ifid_write_o=1.
- Each clock edge:
  - MEMWB <= EXMEM.
  - EXMEM <= IDEX.
  - IDEX <= ID inputs, or a bubble (all fields 0) when stall_o=1 or flush_i=1.
- Forward select is combinational from shadow registers only; no input-to-output path. Zero latency relative to the EX stage.
  - Output is 10 if EXMEM.regwrite && EXMEM.rd!=0 && EXMEM.rd==IDEX.rs1.
  - Else 01 if MEMWB.regwrite && MEMWB.rd!=0 && MEMWB.rd==IDEX.rs1.
  - Else 00.
  - Same rule for B using IDEX.rs2.
  - EX/MEM always wins when both match.
  - Value 11 is never driven.
- Hazard detect (hz): IDEX.memread && IDEX.rd!=0 && (IDEX.rd==id_rs1_i || IDEX.rd==id_rs2_i).
- FSM, two states:
  - RUN: stall_o = hz && !flush_i. On hz && !flush_i, load cnt=LOAD_LAT-1. If LOAD_LAT>1, go to STALL; otherwise stay in RUN (single-cycle stall).
  - STALL: stall_o=1. cnt decrements each cycle; when cnt==0, return to RUN with stall_o=0 on the next cycle.
- Stall length:
  - Stall cycles per hazard are exactly LOAD_LAT.
  - IF/ID is frozen throughout, so the ID inputs are stable.
  - A bubble enters IDEX on every stall cycle.
- flush_i priority: flush_i overrides a stall in any state.
  - stall_o=0 in that cycle.
  - FSM returns to RUN and cnt clears.
  - Bubble into IDEX.
- A back-to-back load-use on the next instruction after a stall exits is detected normally; there are no dead cycles between stalls.
- Reset asserted mid-stall returns to the reset state immediately, without waiting for a clock edge.

Optional Feature:
- Macro FWD_HAZARD_STATS_EN.
- When defined, adds two output ports:
  - stall_cnt_o [15:0]: increments on every cycle with stall_o=1.
  - fwd_cnt_o [15:0]: increments on every cycle where forward_a_o!=00 or forward_b_o!=00, by 1 per cycle, not per operand.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset then idle (all ID inputs 0) -> forward_a_o=forward_b_o=00, stall_o=0, pc_write_o=1, ifid_write_o=1.
- add x5 (rd=5, regwrite=1), then next cycle sub with rs1=5 -> with the sub in EX, forward_a_o=10; one cycle later, with an unrelated instruction, nothing forwards from the stale rd (values revert per rules).
- x5 written two instructions earlier and the instruction in between writes x6; EX instruction has rs2=5 -> forward_b_o=01. If both older instructions write x5 -> forward_b_o=10 (priority).
- Write to x0 (rd=0, regwrite=1) followed by a reader of rs1=0 -> forward_a_o=00.
- Load x7 then consumer with rs1=7, LOAD_LAT=1 -> stall_o=1 for exactly 1 cycle, a bubble in IDEX, then forward_a_o=01 when the consumer reaches EX.
  - Same with LOAD_LAT=2 -> stall_o high for exactly 2 cycles.
- LOAD_LAT=3, flush_i pulsed in the 2nd stall cycle -> stall_o=0 that cycle, FSM in RUN, no further stall.
  - With FWD_HAZARD_STATS_EN, stall_cnt_o=1 after the sequence (only the 1st cycle was a stall).
